program_loader: RTL and testbench

- Writer side of the program-memory interface: loads instruction words into a writable program RAM from board switches, so the demo CPU can run new code without resynthesis.
- Sits beside the control path.
  - It drives the RAM write port.
  - It holds the CPU (program counter and register file) in reset while loading.
  - The fetch side keeps using the RAM read port unchanged.

---
 rtl/program_loader_pkg.sv | 21 ++
 rtl/program_loader_if.sv | 32 +++
 rtl/program_loader_edge_detect.sv | 21 ++
 rtl/program_loader.sv | 125 ++++++++++++
 tb/tb_program_loader.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/program_loader_pkg.sv
// Shared types and defaults for the switch-driven program loader.
// Holds the loader FSM state encoding and default word/address/chunk widths.
package program_loader_pkg;

    localparam int I_SIZE_DEF = 20;
    localparam int P_SIZE_DEF = 5;
    localparam int C_SIZE_DEF = 8;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        WRITE,
        FULL
    } loaderState_t;

    // Chunks needed to cover one instruction word (ceiling division).
    function automatic int nchunk(input int i_size, input int c_size);
        return (i_size + c_size - 1) / c_size;
    endfunction

endpackage

// File: rtl/program_loader_if.sv
// Loader bus: switch/button inputs, RAM write port and status outputs.
// master = loader side (drives RAM/status), slave = board/RAM side.
interface program_loader_if #(
    parameter int I_SIZE = 20,
    parameter int P_SIZE = 5,
    parameter int C_SIZE = 8
);

    logic              loadEn;
    logic              strobe;
    logic [C_SIZE-1:0] dataIn;
    logic              memWe;
    logic [P_SIZE-1:0] memAddr;
    logic [I_SIZE-1:0] memData;
    logic              cpuHold;
    logic [P_SIZE-1:0] loadAddr;
    logic [1:0]        chunkIdx;
    logic              full;

    modport master (
        input  loadEn, strobe, dataIn,
        output memWe, memAddr, memData,
        output cpuHold, loadAddr, chunkIdx, full
    );

    modport slave (
        output loadEn, strobe, dataIn,
        input  memWe, memAddr, memData,
        input  cpuHold, loadAddr, chunkIdx, full
    );

endinterface

// File: rtl/program_loader_edge_detect.sv
// Registered rising-edge detector: pulse = sig & ~sig_q.
// Ports: clk, rst (async high), sig in, pulse out. History resets to RST_VAL.
module edge_detect #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic sig,
    output logic pulse
);

    logic sig_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) sig_q <= RST_VAL;
        else     sig_q <= sig;
    end

    assign pulse = sig & ~sig_q;

endmodule

// File: rtl/program_loader.sv
// Loads instruction words into program RAM from switch chunks, MSB chunk first.
// Ports: clk, rst (async high), bus (master): loadEn/strobe/dataIn in; RAM write + status out.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int I_SIZE = I_SIZE_DEF,
    parameter int P_SIZE = P_SIZE_DEF,
    parameter int C_SIZE = C_SIZE_DEF
) (
    input  logic              clk,
    input  logic              rst,
    program_loader_if.master  bus
);

    localparam int NCHUNK = nchunk(I_SIZE, C_SIZE);
    localparam int AW     = NCHUNK * C_SIZE;
    localparam logic [1:0] LAST = 2'(NCHUNK - 1);

    logic pulse;

    edge_detect #(.RST_VAL(1'b1)) u_edge (
        .clk   (clk),
        .rst   (rst),
        .sig   (bus.strobe),
        .pulse (pulse)
    );

    loaderState_t      state_q, state_d;
    logic [AW-1:0]     asm_q, asm_d;
    logic [P_SIZE-1:0] load_addr_q, load_addr_d;
    logic [1:0]        chunk_q, chunk_d;
    logic              mem_we_q, mem_we_d;
    logic [P_SIZE-1:0] mem_addr_q, mem_addr_d;
    logic [I_SIZE-1:0] mem_data_q, mem_data_d;
    logic              hold_q, hold_d;
    logic              full_q, full_d;

    always_comb begin
        state_d     = state_q;
        asm_d       = asm_q;
        load_addr_d = load_addr_q;
        chunk_d     = chunk_q;
        mem_addr_d  = mem_addr_q;
        mem_data_d  = mem_data_q;

        unique case (state_q)
            IDLE: begin
                if (bus.loadEn) begin
                    state_d     = COLLECT;
                    load_addr_d = '0;
                    chunk_d     = '0;
                    asm_d       = '0;
                end
            end
            COLLECT: begin
                // A final-chunk edge wins over a simultaneous loadEn drop.
                if (pulse) begin
                    asm_d   = (asm_q << C_SIZE) | AW'(bus.dataIn);
                    chunk_d = chunk_q + 2'd1;
                    if (chunk_q == LAST) state_d = WRITE;
                end else if (!bus.loadEn) begin
                    state_d = IDLE;
                end
            end
            WRITE: begin
                chunk_d = '0;
                if (&load_addr_q) begin
                    state_d = FULL;
                end else begin
                    load_addr_d = load_addr_q + 1'b1;
                    state_d     = bus.loadEn ? COLLECT : IDLE;
                end
            end
            FULL: begin
                if (!bus.loadEn) begin
                    state_d     = IDLE;
                    load_addr_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are registered from the next state so they align with it.
        mem_we_d = (state_d == WRITE);
        if (state_d == WRITE) begin
            mem_addr_d = load_addr_q;
            mem_data_d = asm_d[I_SIZE-1:0];
        end
        hold_d = (state_d != IDLE);
        full_d = (state_d == FULL);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            asm_q       <= '0;
            load_addr_q <= '0;
            chunk_q     <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_data_q  <= '0;
            hold_q      <= 1'b0;
            full_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            asm_q       <= asm_d;
            load_addr_q <= load_addr_d;
            chunk_q     <= chunk_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_data_q  <= mem_data_d;
            hold_q      <= hold_d;
            full_q      <= full_d;
        end
    end

    assign bus.memWe    = mem_we_q;
    assign bus.memAddr  = mem_addr_q;
    assign bus.memData  = mem_data_q;
    assign bus.cpuHold  = hold_q;
    assign bus.loadAddr = load_addr_q;
    assign bus.chunkIdx = chunk_q;
    assign bus.full     = full_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: vector table plus multi-cycle sequences.
module tb_program_loader;

    logic clk;
    logic rst;
    int   n_run;
    int   n_fail;
    int   wr_cnt;

    program_loader_if bus ();

    program_loader u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count write pulses away from the active edge.
    always @(negedge clk) if (bus.memWe) wr_cnt++;

    typedef struct {
        logic        load_en;
        logic        strobe;
        logic [7:0]  data;
        logic        we;
        logic [4:0]  addr;
        logic [19:0] mdata;
        logic        hold;
        logic [4:0]  laddr;
        logic [1:0]  cidx;
        logic        full;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        input logic le, input logic st, input logic [7:0] d,
        input logic we, input logic [4:0] a, input logic [19:0] md,
        input logic h, input logic [4:0] la, input logic [1:0] ci,
        input logic f
    );
        vec_t v;
        v.load_en = le; v.strobe = st; v.data = d;
        v.we = we; v.addr = a; v.mdata = md;
        v.hold = h; v.laddr = la; v.cidx = ci; v.full = f;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic press(input logic [7:0] d);
        bus.dataIn = d;
        bus.strobe = 1'b1;
        tick();
        bus.strobe = 1'b0;
    endtask

    function automatic logic [19:0] word_of(input int i);
        logic [7:0] a, b, c;
        a = 8'(i);
        b = 8'(i) ^ 8'h5A;
        c = 8'(i + 1);
        return {a[3:0], b, c};
    endfunction

    int base;

    initial begin
        n_run = 0; n_fail = 0; wr_cnt = 0;
        rst = 1'b1;
        bus.loadEn = 1'b0;
        bus.strobe = 1'b0;
        bus.dataIn = '0;
        tick();
        chk("rst_we", 32'(bus.memWe), 0);
        chk("rst_hold", 32'(bus.cpuHold), 0);
        chk("rst_laddr", 32'(bus.loadAddr), 0);
        chk("rst_cidx", 32'(bus.chunkIdx), 0);
        chk("rst_full", 32'(bus.full), 0);
        chk("rst_data", 32'(bus.memData), 0);
        rst = 1'b0;
        tick();

        // Single word A5,3C,7E -> 0x53C7E at address 0.
        vecs.push_back(mk(1, 0, 8'h00, 0, 0, 0, 1, 0, 0, 0));
        vecs.push_back(mk(1, 1, 8'hA5, 0, 0, 0, 1, 0, 1, 0));
        vecs.push_back(mk(1, 0, 8'hA5, 0, 0, 0, 1, 0, 1, 0));
        vecs.push_back(mk(1, 1, 8'h3C, 0, 0, 0, 1, 0, 2, 0));
        vecs.push_back(mk(1, 0, 8'h3C, 0, 0, 0, 1, 0, 2, 0));
        vecs.push_back(mk(1, 1, 8'h7E, 1, 0, 20'h53C7E, 1, 0, 3, 0));
        vecs.push_back(mk(1, 0, 8'h7E, 0, 0, 20'h53C7E, 1, 1, 0, 0));
        foreach (vecs[i]) begin
            bus.loadEn = vecs[i].load_en;
            bus.strobe = vecs[i].strobe;
            bus.dataIn = vecs[i].data;
            tick();
            chk($sformatf("v%0d_we", i), 32'(bus.memWe), 32'(vecs[i].we));
            chk($sformatf("v%0d_addr", i), 32'(bus.memAddr), 32'(vecs[i].addr));
            chk($sformatf("v%0d_data", i), 32'(bus.memData), 32'(vecs[i].mdata));
            chk($sformatf("v%0d_hold", i), 32'(bus.cpuHold), 32'(vecs[i].hold));
            chk($sformatf("v%0d_laddr", i), 32'(bus.loadAddr), 32'(vecs[i].laddr));
            chk($sformatf("v%0d_cidx", i), 32'(bus.chunkIdx), 32'(vecs[i].cidx));
            chk($sformatf("v%0d_full", i), 32'(bus.full), 32'(vecs[i].full));
        end

        // Held strobe gives exactly one capture.
        bus.dataIn = 8'h11;
        bus.strobe = 1'b1;
        repeat (10) tick();
        chk("held_cidx", 32'(bus.chunkIdx), 1);
        bus.strobe = 1'b0;
        tick();
        chk("held_cidx2", 32'(bus.chunkIdx), 1);

        // Abort after two chunks.
        base = wr_cnt;
        press(8'h22);
        tick();
        chk("abort_cidx", 32'(bus.chunkIdx), 2);
        bus.loadEn = 1'b0;
        tick();
        chk("abort_hold", 32'(bus.cpuHold), 0);
        chk("abort_we", 32'(bus.memWe), 0);
        tick();
        chk("abort_nowr", 32'(wr_cnt - base), 0);
        bus.loadEn = 1'b1;
        tick();
        chk("resume_hold", 32'(bus.cpuHold), 1);
        chk("resume_laddr", 32'(bus.loadAddr), 0);
        chk("resume_cidx", 32'(bus.chunkIdx), 0);

        // Strobe high through reset produces no capture.
        rst = 1'b1;
        bus.strobe = 1'b1;
        tick();
        chk("rst2_hold", 32'(bus.cpuHold), 0);
        chk("rst2_laddr", 32'(bus.loadAddr), 0);
        rst = 1'b0;
        repeat (3) tick();
        chk("rststb_hold", 32'(bus.cpuHold), 1);
        chk("rststb_cidx", 32'(bus.chunkIdx), 0);
        bus.strobe = 1'b0;
        tick();

        // Fill all 32 addresses.
        base = wr_cnt;
        for (int i = 0; i < 32; i++) begin
            logic [7:0] a, b, c;
            a = 8'(i);
            b = 8'(i) ^ 8'h5A;
            c = 8'(i + 1);
            press(a); tick();
            press(b); tick();
            press(c);
            chk($sformatf("fill%0d_we", i), 32'(bus.memWe), 1);
            chk($sformatf("fill%0d_addr", i), 32'(bus.memAddr), 32'(i));
            chk($sformatf("fill%0d_data", i), 32'(bus.memData), 32'(word_of(i)));
            tick();
        end
        chk("fill_cnt", 32'(wr_cnt - base), 32);
        chk("full_flag", 32'(bus.full), 1);
        chk("full_hold", 32'(bus.cpuHold), 1);
        chk("full_laddr", 32'(bus.loadAddr), 31);
        base = wr_cnt;
        repeat (3) begin
            press(8'hFF);
            tick();
        end
        chk("full_nowr", 32'(wr_cnt - base), 0);
        chk("full_stay", 32'(bus.full), 1);
        bus.loadEn = 1'b0;
        tick();
        chk("unfull_flag", 32'(bus.full), 0);
        chk("unfull_hold", 32'(bus.cpuHold), 0);
        chk("unfull_laddr", 32'(bus.loadAddr), 0);

        // Final edge together with loadEn drop still writes.
        bus.loadEn = 1'b1;
        tick();
        press(8'h01); tick();
        press(8'h02); tick();
        press(8'h03); tick();
        press(8'hC4); tick();
        press(8'h55);
        tick();
        bus.loadEn = 1'b0;
        press(8'hAA);
        chk("sim_we", 32'(bus.memWe), 1);
        chk("sim_addr", 32'(bus.memAddr), 1);
        chk("sim_data", 32'(bus.memData), 32'h455AA);
        tick();
        chk("sim_we_off", 32'(bus.memWe), 0);
        chk("sim_idle_hold", 32'(bus.cpuHold), 0);

        // Async reset during a write pulse.
        bus.loadEn = 1'b1;
        tick();
        press(8'h0F); tick();
        press(8'h10); tick();
        press(8'h20);
        chk("arst_pre_we", 32'(bus.memWe), 1);
        base = wr_cnt;
        #2;
        rst = 1'b1;
        #1;
        chk("arst_we", 32'(bus.memWe), 0);
        chk("arst_addr", 32'(bus.memAddr), 0);
        chk("arst_data", 32'(bus.memData), 0);
        chk("arst_hold", 32'(bus.cpuHold), 0);
        chk("arst_cidx", 32'(bus.chunkIdx), 0);
        bus.loadEn = 1'b0;
        tick();
        rst = 1'b0;
        repeat (4) tick();
        chk("arst_nowr", 32'(wr_cnt - base), 0);
        chk("arst_idle", 32'(bus.cpuHold), 0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
